// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads to the instruction memory,
// follows its fixed two-cycle read latency with a two-stage {valid, pc} pipeline,
// and buffers returned words with their PCs in a small FIFO for decode.
// Issue is credit-limited so the FIFO can never overflow, and a redirect
// flushes both the in-flight reads and the buffer in the same cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_read_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_q,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_s0_valid;
  logic [31:0]   r_s0_pc;
  logic          r_s1_valid;
  logic [31:0]   r_s1_pc;
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_inflight;
  logic [OW-1:0] w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  // Credits: buffered entries plus reads still travelling through memory.
  // A pop in this cycle is deliberately not counted until the next cycle.
  assign w_inflight  = CW'(r_s0_valid) + CW'(r_s1_valid);
  assign w_occupancy = {1'b0, r_count} + {1'b0, w_inflight};
  assign w_issue     = rst_n & fetch_en & ~redirect_valid & (w_occupancy < DEPTH_O);

  assign imem_read_en = w_issue;
  assign imem_addr    = {r_fetch_pc[31:2], 2'b00};

  // A redirect kills the response landing this cycle and any pop of the old head.
  assign w_push = r_s1_valid & ~redirect_valid;
  assign inst_valid = (r_count != '0);
  assign w_pop  = inst_valid & inst_ready & ~redirect_valid;

  assign inst    = inst_valid ? r_fifo_inst[r_head] : 32'h0;
  assign inst_pc = inst_valid ? r_fifo_pc[r_head]   : 32'h0;

  // Low address bits are always treated as zero.
  assign w_unused = &{1'b0, redirect_pc[1:0], r_fetch_pc[1:0]};

  // Fetch PC: reload on redirect, otherwise step one word per issued request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Read-latency tracker; clearing the valids is what drops stale memory data.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s0_valid <= w_issue;
      r_s1_valid <= r_s0_valid;
    end
    r_s0_pc <= imem_addr;
    r_s1_pc <= r_s0_pc;
  end

  // Per-entry buffer storage, written at the tail when a response lands.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      // Capture the returned word and its PC into this slot.
      always_ff @(posedge clk) begin
        if (w_push && (r_tail == AW'(gi))) begin
          r_fifo_inst[gi] <= imem_q;
          r_fifo_pc[gi]   <= r_s1_pc;
        end
      end
    end
  endgenerate

  // Head/tail pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit scheme must make a write into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      assert (r_count != DEPTH_C);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized
// traffic, all checked each cycle against a queue-based reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_read_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_q;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_read_en   (imem_read_en),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memory: fixed two-cycle read latency, junk when no read is due.
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [31:0] d1_a, d2_a, junk;
  always @(posedge clk) begin
    d1_v <= imem_read_en;
    d1_a <= imem_addr;
    d2_v <= d1_v;
    d2_a <= d1_a;
    junk <= $urandom;
  end
  assign imem_q = d2_v ? mem_word(d2_a) : junk;

  // Reference model: next fetch PC, outstanding reads with age, buffered PCs.
  typedef struct {
    logic [31:0] pc;
    int          age;
  } fl_t;

  logic [31:0] m_pc;
  fl_t         infl[$];
  logic [31:0] mfifo[$];
  bit          m_init = 1'b0;

  int          n_re;
  bit          last_re;
  bit          last_iv;
  logic [31:0] last_addr;

  task automatic cycle(input bit rn, input bit fe, input bit rv,
                       input logic [31:0] rpc, input bit rdy);
    bit          iss;
    logic [31:0] obs_pc, obs_inst;
    fl_t         keep[$];
    fl_t         e;
    rst_n = rn; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    @(negedge clk);
    iss = rn && m_init && fe && !rv && ((mfifo.size() + infl.size()) < 4);
    if (m_init) begin
      check("read_en",    32'(imem_read_en), 32'(iss));
      check("imem_addr",  imem_addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(mfifo.size() > 0));
      check("inst_pc",    inst_pc, (mfifo.size() > 0) ? mfifo[0] : 32'h0);
      check("inst",       inst, (mfifo.size() > 0) ? mem_word(mfifo[0]) : 32'h0);
    end
    last_re = imem_read_en; last_addr = imem_addr; last_iv = inst_valid;
    obs_pc = inst_pc; obs_inst = inst;
    if (imem_read_en) n_re++;
    @(posedge clk);
    if (!rn) begin
      m_pc = 32'h0; infl.delete(); mfifo.delete(); m_init = 1'b1;
    end else if (rv) begin
      infl.delete(); mfifo.delete(); m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (mfifo.size() > 0 && rdy) begin
        $display("pop pc=%h inst=%h", obs_pc, obs_inst);
        void'(mfifo.pop_front());
      end
      keep.delete();
      foreach (infl[i]) begin
        if (infl[i].age == 1) mfifo.push_back(infl[i].pc);
        else begin
          e = infl[i]; e.age++; keep.push_back(e);
        end
      end
      infl = keep;
      if (iss) begin
        infl.push_back('{m_pc, 0});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    bit          rn, fe, rv, rdy;
    logic [31:0] rpc;
    n_re = 0;

    // Reset and straight-line fetch.
    do_reset();
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure: exactly four requests, then drain and resume.
    do_reset();
    n_re = 0;
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("bp_issues", 32'(n_re), 32'd4);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with reads of 0x8 and 0xC in flight.
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("redir_re", 32'(last_re), 32'd1);
    check("redir_addr", last_addr, 32'h40);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect coincident with a pop and a landing response.
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h103, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("redir_empty", 32'(last_iv), 32'd0);
    check("redir_addr_al", last_addr, 32'h100);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // fetch_en gating.
    do_reset();
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    n_re = 0;
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("gated_issues", 32'(n_re), 32'd0);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap, then reset with reads in flight.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_addr0", last_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("wrap_addr1", last_addr, 32'h0000_0000);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rn  = ($urandom_range(99) != 0);
      fe  = ($urandom_range(9) != 0);
      rv  = ($urandom_range(19) == 0);
      rdy = ($urandom_range(9) < 7);
      case ($urandom_range(3))
        0:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        1:       rpc = 32'($urandom_range(255));
        default: rpc = $urandom;
      endcase
      cycle(rn, fe, rv, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Initiator side of the instruction-memory read interface: generates word-aligned read requests (read enable plus byte address) to the instruction memory, tracks the memory's fixed two-cycle read latency, and captures returned words with their PCs into a small FIFO presented to decode with a valid/ready handshake. Sits between the PC/redirect logic of the processor and the instruction BRAM. Handles backpressure via credits and kills in-flight reads on a redirect (branch, JAL/JALR, trap).

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 4.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_en  in  1  permits issuing new requests; in-flight reads still complete.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
- imem_read_en  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the request; bits [1:0] always 0.
- imem_q  in  32  read data; valid exactly 2 cycles after the request cycle.
- inst_valid  out  1  FIFO head holds an instruction.
- inst  out  32  head instruction word; 32'h0 when inst_valid=0.
- inst_pc  out  32  PC of head instruction; 32'h0 when inst_valid=0.
- inst_ready  in  1  decode accepts head this cycle.

## Operation
- fetch_pc register: reset to RESET_PC. imem_addr = fetch_pc with bits [1:0] forced to 0, combinational.
- Issue condition: fetch_en=1, redirect_valid=0, and count + inflight < FIFO_DEPTH. When met, imem_read_en=1, and fetch_pc advances by 4 with 32-bit wrap (FFFF_FFFC -> 0000_0000).
- In-flight tracking: 2-stage shift pipeline of {valid, pc}. Stage 0 loads {issue, fetch_pc} each cycle. Stage 1 takes stage 0. inflight = number of valid stages (0..2).
- Response capture: when stage 1 is valid, imem_q is written to the FIFO tail with the stage-1 pc. The credit check guarantees the FIFO is never full at this point. A write to a full FIFO is a design error; assertion only.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle are both performed, and count is unchanged.
- Credits count the current count. A same-cycle pop frees a slot only from the next cycle.
- Redirect, in the cycle redirect_valid=1:
  - no request is issued;
  - both in-flight stages are invalidated, so a response arriving that cycle is dropped;
  - the FIFO is cleared (head=tail=count=0); a simultaneous pop is discarded;
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - The first request to the new PC is issued the following cycle if fetch_en=1.
- fetch_en=0: no issue. fetch_pc holds. Outstanding reads land normally. Redirects are still honoured.
- Reset mid-operation: all in-flight reads are dropped and the FIFO is cleared. Memory data arriving after reset is ignored because the stage valids are 0.
- Reset values: imem_read_en=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, count=0, stage valids=0.

## Timing
- Request in cycle t (imem_read_en=1 sampled at the edge ending t). Data is on imem_q during t+2 and written at the edge ending t+2. inst_valid rises in t+3.
- Fetch-to-decode latency: 3 cycles. First cycle after rst_n rises: request RESET_PC. The first inst_valid comes 3 cycles later.
- Throughput: 1 instruction/cycle sustained with inst_ready held high (steady state count ≤ 1, inflight = 2, total 3 < 4).
- Redirect in cycle r: the request to redirect_pc is in r+1 and inst_valid for it is in r+4. No instruction older than the redirect appears after cycle r.
- Backpressure: with inst_ready=0, at most FIFO_DEPTH requests are outstanding or buffered, and issue stops exactly when count + inflight = FIFO_DEPTH.

## Test plan
- Straight-line fetch: memory model returns addr-derived words. RESET_PC=0 and inst_ready=1 give imem_addr 0,4,8,… on consecutive cycles. inst_pc/inst pairs 0,4,8… arrive one per cycle, the first 3 cycles after reset release.
- Backpressure: hold inst_ready=0. Exactly 4 requests (0,4,8,C) are issued, then imem_read_en=0. Raising inst_ready drains 0,4,8,C in order, and issue resumes at 0x10 the cycle after the first pop is counted.
- Redirect with 2 in flight: redirect_valid=1, redirect_pc=0x40 while reads of 0x8 and 0xC are pending. Neither 0x8 nor 0xC appears at the output. The next request is 0x40 in r+1, and inst_pc=0x40 is valid in r+4.
- Redirect coincident with pop and response: FIFO holds 2 entries, inst_ready=1, redirect_pc=0x103. The FIFO empties with inst_valid=0 next cycle. imem_addr=0x100 and the returned inst_pc=0x100.
- fetch_en gating: drop fetch_en after 2 requests. Both responses are still delivered, with no further read_en. Re-enabling resumes at the next sequential PC.
- Wrap and reset: redirect_pc=0xFFFF_FFFC gives requests FFFF_FFFC then 0000_0000. Asserting rst_n=0 with 2 in flight leaves inst_valid=0 and no stale data after release, and the first output is RESET_PC.
